// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the sequential multiply/divide unit.
//   md_op_t    : operation codes accepted on muldiv_seq.op (codes 6 and 7 are no-ops)
//   md_state_t : controller states
//   MD_ITER    : number of radix-2 iterations per multiply/divide
package md_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 5;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: final sign correction applied in the FIX state.
//   i_is_div : 1 = accumulator holds {remainder, quotient}; 0 = 64-bit product
//   i_neg_lo : negate the product (multiply) or the quotient (divide)
//   i_neg_hi : negate the remainder (divide only)
//   i_acc    : unsigned magnitude result from the iteration datapath
//   o_hi     : value to be written to HI
//   o_lo     : value to be written to LO
module muldiv_sign_fix (
  input  logic        i_is_div,
  input  logic        i_neg_lo,
  input  logic        i_neg_hi,
  input  logic [63:0] i_acc,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_prod = i_neg_lo ? (~i_acc + 64'd1) : i_acc;
  assign w_quo  = i_neg_lo ? (~i_acc[31:0] + 32'd1) : i_acc[31:0];
  assign w_rem  = i_neg_hi ? (~i_acc[63:32] + 32'd1) : i_acc[63:32];

  assign o_hi = i_is_div ? w_rem : w_prod[63:32];
  assign o_lo = i_is_div ? w_quo : w_prod[31:0];

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS-style HI/LO multiply/divide unit.
//   CLK, RST (synchronous, active-high)
//   start/op/a/b : operation request, taken only in IDLE
//   flush        : abandon any in-flight operation (wins over start)
//   rd_req       : pipeline wants HI/LO this cycle; stall = rd_req & busy
//   busy, done   : iteration in progress / one-cycle result-written pulse
//   HI, LO       : architectural result registers
// Build option: define MULDIV_FAST_MUL_EN for single-step MULT/MULTU.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO, div-by-zero, undefined ops finish here
// RUN   | 32 radix-2 shift-add or restoring-divide iterations on magnitudes
// FIX   | sign correction, HI/LO written, done pulsed
module muldiv_seq import md_pkg::*; (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        rd_req,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_t           r_state;
  md_state_t           w_state_nxt;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [63:0]         r_acc;
  logic [31:0]         r_opnd;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic                r_is_div;
  logic                r_neg_lo;
  logic                r_neg_hi;
  logic                r_done;

  logic                w_accept;
  logic                w_is_mul;
  logic                w_is_div;
  logic                w_signed;
  logic                w_b_zero;
  logic                w_mul_iter;
  logic                w_launch;
  logic [31:0]         w_mag_a;
  logic [31:0]         w_mag_b;
  logic [32:0]         w_mul_sum;
  logic [63:0]         w_mul_step;
  logic [32:0]         w_div_shift;
  logic [33:0]         w_div_diff;
  logic [63:0]         w_div_step;
  logic [31:0]         w_fix_hi;
  logic [31:0]         w_fix_lo;

  assign w_accept = (r_state == IDLE) & start & ~flush;
  assign w_is_mul = (op == MULT) | (op == MULTU);
  assign w_is_div = (op == DIV) | (op == DIVU);
  assign w_signed = (op == MULT) | (op == DIV);
  assign w_b_zero = (b == 32'd0);

  assign w_mag_a = (w_signed & a[31]) ? (~a + 32'd1) : a;
  assign w_mag_b = (w_signed & b[31]) ? (~b + 32'd1) : b;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] w_fast_a;
  logic [63:0] w_fast_b;
  logic [63:0] w_fast_prod;

  // Sign-extending to 64 bits makes the truncated product correct for both
  // signed and unsigned operands.
  assign w_fast_a    = {{32{w_signed & a[31]}}, a};
  assign w_fast_b    = {{32{w_signed & b[31]}}, b};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_mul_iter  = 1'b0;
`else
  assign w_mul_iter  = w_is_mul;
`endif

  assign w_launch = w_accept & (w_mul_iter | (w_is_div & ~w_b_zero));

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  // The shifted remainder can reach 33 bits, so compare in 34 bits.
  assign w_div_shift = r_acc[63:31];
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
  assign w_div_step  = w_div_diff[33] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                      : {w_div_diff[31:0],  r_acc[30:0], 1'b1};

  muldiv_sign_fix u_sign_fix (
    .i_is_div (r_is_div),
    .i_neg_lo (r_neg_lo),
    .i_neg_hi (r_neg_hi),
    .i_acc    (r_acc),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_state_nxt = RUN;
      RUN:     if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_accept) begin
        if (w_launch) begin
          r_is_div <= w_is_div;
          r_neg_lo <= w_signed & (a[31] ^ b[31]);
          r_neg_hi <= w_signed & a[31];
          r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
          r_acc    <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
          r_cnt    <= MD_CNT_W'(MD_ITER - 1);
        end else if (w_is_div) begin
          // divide by zero: completes immediately, HI/LO untouched
          r_done <= 1'b0 | 1'b1;
        end else if (op == MTHI) begin
          r_hi   <= a;
          r_done <= 1'b1;
        end else if (op == MTLO) begin
          r_lo   <= a;
          r_done <= 1'b1;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (w_is_mul) begin
          r_hi   <= w_fast_prod[63:32];
          r_lo   <= w_fast_prod[31:0];
          r_done <= 1'b1;
        end
`endif
      end else if (!flush) begin
        if (r_state == RUN) begin
          r_acc <= r_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt - 1'b1;
        end else if (r_state == FIX) begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy  = (r_state != IDLE);
  assign stall = rd_req & busy;
  assign done  = r_done;
  assign HI    = r_hi;
  assign LO    = r_lo;

endmodule
